// File: rtl/mem_access_stage.sv
// MEM stage: word load/store over a req/ack port, owns the MEM/WB register (1-cycle latency).
// Holds mem_stall high while an access waits for ack; aborts with bus_err after TIMEOUT req cycles.
module mem_access_stage #(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWrite_in,
  input  logic              MemRead_in,
  input  logic              MemWrite_in,
  input  logic              MemToReg_in,
  input  logic [31:0]       alu_out_in,
  input  logic [31:0]       rt_data_in,
  input  logic [4:0]        rd_in,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ack,
  output logic              mem_stall,
  output logic              RegWrite_wb,
  output logic              MemToReg_wb,
  output logic [31:0]       mem_data_wb,
  output logic [31:0]       alu_out_wb,
  output logic [4:0]        rd_wb,
  output logic              misalign_err,
  output logic              bus_err
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]    state;
  logic [CW-1:0] wait_cnt;

  logic mem_op, aligned, misalign, timeout, done, load_done;

  assign mem_op  = MemRead_in | MemWrite_in;
  assign aligned = (alu_out_in[1:0] == 2'b00);

  // A request in WAIT is implied: upstream is frozen, so the op is still presented.
  assign dmem_req   = !rst && ((state == IDLE && mem_op && aligned) || state == WAIT);
  assign dmem_we    = MemWrite_in;
  assign dmem_addr  = alu_out_in[ADDR_W-1:0];
  assign dmem_wdata = rt_data_in;

  assign misalign  = (state == IDLE) && mem_op && !aligned;
  assign timeout   = !rst && (state == WAIT) && !dmem_ack && (wait_cnt == CW'(TIMEOUT - 1));
  assign done      = dmem_req && dmem_ack;
  assign load_done = done && MemRead_in && !MemWrite_in;
  assign mem_stall = dmem_req && !dmem_ack && !timeout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else if (state == IDLE) begin
      if (dmem_req && !dmem_ack) begin
        state    <= WAIT;
        wait_cnt <= CW'(1);
      end
    end else begin
      if (done || timeout) begin
        state    <= IDLE;
        wait_cnt <= '0;
      end else begin
        wait_cnt <= wait_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      RegWrite_wb  <= 1'b0;
      MemToReg_wb  <= 1'b0;
      mem_data_wb  <= '0;
      alu_out_wb   <= '0;
      rd_wb        <= '0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
    end else if (mem_stall) begin
      // Bubble: control cleared, data fields keep their last values.
      RegWrite_wb  <= 1'b0;
      MemToReg_wb  <= 1'b0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
    end else begin
      RegWrite_wb  <= RegWrite_in && !timeout && !misalign;
      MemToReg_wb  <= MemToReg_in;
      alu_out_wb   <= alu_out_in;
      rd_wb        <= rd_in;
      misalign_err <= misalign;
      bus_err      <= timeout;
      if (load_done) mem_data_wb <= dmem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with TIMEOUT=8; inputs change 1 time unit after each rising edge.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWrite_in, MemRead_in, MemWrite_in, MemToReg_in;
  logic [31:0] alu_out_in, rt_data_in;
  logic [4:0]  rd_in;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic        mem_stall, RegWrite_wb, MemToReg_wb;
  logic [31:0] mem_data_wb, alu_out_wb;
  logic [4:0]  rd_wb;
  logic        misalign_err, bus_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT(8), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .RegWrite_in(RegWrite_in), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .MemToReg_in(MemToReg_in), .alu_out_in(alu_out_in), .rt_data_in(rt_data_in),
    .rd_in(rd_in), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .mem_stall(mem_stall), .RegWrite_wb(RegWrite_wb), .MemToReg_wb(MemToReg_wb),
    .mem_data_wb(mem_data_wb), .alu_out_wb(alu_out_wb), .rd_wb(rd_wb),
    .misalign_err(misalign_err), .bus_err(bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rw, input logic mr, input logic mw, input logic m2r,
                       input logic [31:0] alu, input logic [31:0] rt, input logic [4:0] rd);
    RegWrite_in = rw; MemRead_in = mr; MemWrite_in = mw; MemToReg_in = m2r;
    alu_out_in = alu; rt_data_in = rt; rd_in = rd;
  endtask

  initial begin
    rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    // Load presented during reset must not raise req.
    drive(1, 1, 0, 1, 32'h10, 32'h0, 5'd5);
    tick; tick;
    chk("rst_req", dmem_req, 0);
    chk("rst_stall", mem_stall, 0);
    chk("rst_regwrite", RegWrite_wb, 0);
    chk("rst_memdata", mem_data_wb, 0);
    chk("rst_rd", rd_wb, 0);
    chk("rst_errs", {misalign_err, bus_err}, 0);

    // 1: load with same-cycle ack
    rst = 1'b0; dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
    #1;
    chk("t1_req", dmem_req, 1);
    chk("t1_we", dmem_we, 0);
    chk("t1_addr", dmem_addr, 32'h10);
    chk("t1_stall", mem_stall, 0);
    tick;
    chk("t1_memdata", mem_data_wb, 32'hDEADBEEF);
    chk("t1_regwrite", RegWrite_wb, 1);
    chk("t1_rd", rd_wb, 5);
    chk("t1_memtoreg", MemToReg_wb, 1);

    // 2: store, ack on 3rd req cycle
    dmem_ack = 1'b0; dmem_rdata = 32'h55555555;
    drive(0, 0, 1, 0, 32'h20, 32'h1234, 5'd0);
    #1;
    chk("t2_req_c1", dmem_req, 1);
    chk("t2_we_c1", dmem_we, 1);
    chk("t2_stall_c1", mem_stall, 1);
    tick;
    chk("t2_bubble1_rw", RegWrite_wb, 0);
    chk("t2_bubble1_alu_hold", alu_out_wb, 32'h10);
    chk("t2_stall_c2", mem_stall, 1);
    chk("t2_addr_c2", dmem_addr, 32'h20);
    chk("t2_wdata_c2", dmem_wdata, 32'h1234);
    tick;
    chk("t2_bubble2_m2r", MemToReg_wb, 0);
    dmem_ack = 1'b1;
    #1;
    chk("t2_req_c3", dmem_req, 1);
    chk("t2_stall_c3", mem_stall, 0);
    tick;
    chk("t2_retire_alu", alu_out_wb, 32'h20);
    chk("t2_retire_memdata", mem_data_wb, 32'hDEADBEEF);
    chk("t2_retire_rw", RegWrite_wb, 0);

    // 3: load with no ack, aborts after 8 req cycles
    dmem_ack = 1'b0;
    drive(1, 1, 0, 1, 32'h40, 32'h0, 5'd7);
    #1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t3_req_%0d", i), dmem_req, 1);
      chk($sformatf("t3_stall_%0d", i), mem_stall, (i < 7) ? 32'd1 : 32'd0);
      if (i < 7) chk($sformatf("t3_nobuserr_%0d", i), bus_err, 0);
      tick;
    end
    chk("t3_buserr", bus_err, 1);
    chk("t3_regwrite", RegWrite_wb, 0);
    chk("t3_rd", rd_wb, 7);
    drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    #1;
    chk("t3_req_after", dmem_req, 0);
    tick;
    chk("t3_buserr_pulse", bus_err, 0);

    // 4: misaligned load
    drive(1, 1, 0, 1, 32'h13, 32'h0, 5'd9);
    #1;
    chk("t4_req", dmem_req, 0);
    chk("t4_stall", mem_stall, 0);
    tick;
    chk("t4_misalign", misalign_err, 1);
    chk("t4_regwrite", RegWrite_wb, 0);
    chk("t4_rd", rd_wb, 9);
    drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    tick;
    chk("t4_misalign_pulse", misalign_err, 0);

    // 5: ALU ops, 1-wait load, ALU op
    for (int i = 1; i <= 3; i++) begin
      drive(1, 0, 0, 0, 32'h100 + 32'(i), 32'h0, 5'(i));
      tick;
      chk($sformatf("t5_alu%0d_rd", i), rd_wb, i);
      chk($sformatf("t5_alu%0d_val", i), alu_out_wb, 32'h100 + 32'(i));
      chk($sformatf("t5_alu%0d_rw", i), RegWrite_wb, 1);
    end
    drive(1, 1, 0, 1, 32'h80, 32'h0, 5'd4);
    #1;
    chk("t5_ld_stall", mem_stall, 1);
    tick;
    chk("t5_ld_bubble_rw", RegWrite_wb, 0);
    chk("t5_ld_bubble_rd_hold", rd_wb, 3);
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFE0004;
    #1;
    chk("t5_ld_stall_end", mem_stall, 0);
    tick;
    chk("t5_ld_rd", rd_wb, 4);
    chk("t5_ld_data", mem_data_wb, 32'hCAFE0004);
    chk("t5_ld_rw", RegWrite_wb, 1);
    dmem_ack = 1'b0;
    drive(1, 0, 0, 0, 32'h106, 32'h0, 5'd6);
    tick;
    chk("t5_post_rd", rd_wb, 6);
    chk("t5_post_alu", alu_out_wb, 32'h106);

    // 6: reset on 2nd WAIT cycle, then late ack
    drive(1, 1, 0, 1, 32'h90, 32'h0, 5'd8);
    tick;
    tick;
    chk("t6_req_wait2", dmem_req, 1);
    rst = 1'b1;
    #1;
    chk("t6_req_rst", dmem_req, 0);
    chk("t6_stall_rst", mem_stall, 0);
    tick;
    chk("t6_rw", RegWrite_wb, 0);
    chk("t6_rd", rd_wb, 0);
    chk("t6_alu", alu_out_wb, 0);
    chk("t6_memdata", mem_data_wb, 0);
    chk("t6_errs", {misalign_err, bus_err}, 0);
    rst = 1'b0;
    drive(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    dmem_ack = 1'b1; dmem_rdata = 32'hBADBAD00;
    #1;
    chk("t6_late_req", dmem_req, 0);
    chk("t6_late_stall", mem_stall, 0);
    tick;
    chk("t6_late_memdata", mem_data_wb, 0);
    chk("t6_late_buserr", bus_err, 0);
    // Back in IDLE: a same-cycle-ack load must not stall.
    dmem_ack = 1'b0;
    drive(1, 1, 0, 1, 32'hA0, 32'h0, 5'd10);
    #1;
    chk("t6_idle_req", dmem_req, 1);
    chk("t6_idle_stall", mem_stall, 1);
    dmem_ack = 1'b1; dmem_rdata = 32'h0000A0A0;
    #1;
    chk("t6_idle_ack_stall", mem_stall, 0);
    tick;
    chk("t6_idle_data", mem_data_wb, 32'h0000A0A0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
